// File: rtl/alu_pipe.sv
// alu_pipe: clocked 16-op ALU with iterative MUL/DIV and valid/ready handshakes; define ALU_PIPE_FLAGS_EN for zero/carry/ovf flags
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int CMD_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [CMD_W-1:0]   command,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               div_err
`ifdef ALU_PIPE_FLAGS_EN
    ,
    output logic               zero,
    output logic               carry,
    output logic               ovf
`endif
);
    typedef enum logic [1:0] {IDLE, BUSY_MUL, BUSY_DIV} state_t;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0] ONE = 1;
    state_t state, state_n;
    logic [WIDTH-1:0] op_b, div_diff;
    logic [2*WIDTH-1:0] acc, acc_n, res1, res_q;
    logic [CW-1:0] cnt;
    logic [WIDTH:0] sum, diff, mul_hi, div_sh;
    logic accept, single, done, div_ge;

    assign accept = in_valid && in_ready;
    assign single = command != 4'd4 && command != 4'd5;
    assign done = state != IDLE && cnt == CW'(1);

    always_ff @(posedge clk) state <= rst ? IDLE : state_n;

    always_comb begin
        state_n = state == IDLE ? (accept && !single ? (command == 4'd4 ? BUSY_MUL : BUSY_DIV) : IDLE)
                : done ? IDLE : state;
    end

    always_comb begin
        in_ready = enable && !rst && state == IDLE && (!out_valid || out_ready);
        out = enable ? res_q : '0;
    end

    // acc holds {hi, lo}: product halves for MUL, {remainder, quotient} for DIV
    always_comb begin
        mul_hi = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_b} : '0);
        div_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge = div_sh >= {1'b0, op_b};
        div_diff = div_sh[WIDTH-1:0] - op_b;
        acc_n = state == BUSY_MUL ? {mul_hi, acc[WIDTH-1:1]}
              : {div_ge ? div_diff : div_sh[WIDTH-1:0], acc[WIDTH-2:0], div_ge};
    end

    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        res1 = '0;
        case (command)
            4'd0: res1[WIDTH:0] = sum;
            4'd1: res1[WIDTH:0] = {1'b0, a} + ONE;
            4'd2: res1[WIDTH:0] = diff;
            4'd3: res1[WIDTH:0] = {1'b0, a} - ONE;
            4'd6: res1[WIDTH:0] = {a, 1'b0};
            4'd7: res1[WIDTH-1:0] = a >> 1;
            4'd8: res1[WIDTH-1:0] = a & b;
            4'd9: res1[WIDTH-1:0] = a | b;
            4'd10: res1[WIDTH-1:0] = ~a;
            4'd11: res1[WIDTH-1:0] = ~(a & b);
            4'd12: res1[WIDTH-1:0] = ~(a | b);
            4'd13: res1[WIDTH-1:0] = a ^ b;
            4'd14: res1[WIDTH-1:0] = ~(a ^ b);
            4'd15: res1[WIDTH-1:0] = a;
            default: res1 = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            res_q <= '0;
            div_err <= 1'b0;
            acc <= '0;
            op_b <= '0;
            cnt <= '0;
        end else begin
            if (accept) begin
                op_b <= b;
                acc <= {{WIDTH{1'b0}}, a};
                cnt <= CW'(WIDTH);
            end else if (state != IDLE) begin
                acc <= acc_n;
                cnt <= cnt - CW'(1);
            end
            if (accept && single) begin
                res_q <= res1;
                div_err <= 1'b0;
                out_valid <= 1'b1;
            end else if (done) begin
                res_q <= acc_n;
                div_err <= state == BUSY_DIV && op_b == '0;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_PIPE_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            zero <= 1'b0;
            carry <= 1'b0;
            ovf <= 1'b0;
        end else if (accept && single) begin
            zero <= res1[WIDTH-1:0] == '0;
            carry <= res1[WIDTH];
            ovf <= command == 4'd0 ? a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1]
                 : command == 4'd2 ? a[WIDTH-1] != b[WIDTH-1] && diff[WIDTH-1] != a[WIDTH-1] : 1'b0;
        end else if (done) begin
            zero <= acc_n == '0;
            carry <= 1'b0;
            ovf <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=8) with a behavioural arithmetic model
module tb_alu_pipe;
    logic clk = 0, rst = 1, enable = 1, in_valid = 0, out_ready = 1, rnd = 0;
    logic [7:0] a = 0, b = 0;
    logic [3:0] command = 0;
    logic in_ready, out_valid, div_err;
    logic [15:0] out;
    logic [16:0] sb[$];
    int checks = 0, errors = 0;
`ifdef ALU_PIPE_FLAGS_EN
    logic zero, carry, ovf;
`endif

    alu_pipe #(.WIDTH(8), .CMD_W(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .command(command), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .div_err(div_err)
`ifdef ALU_PIPE_FLAGS_EN
        , .zero(zero), .carry(carry), .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] model(input int c, input int x, input int y);
        int r;
        logic e;
        e = 0;
        case (c)
            0: r = x + y;
            1: r = x + 1;
            2: r = ((x - y) & 255) | (x < y ? 256 : 0);
            3: r = ((x - 1) & 255) | (x == 0 ? 256 : 0);
            4: r = x * y;
            5: if (y == 0) begin r = (x << 8) | 255; e = 1; end else r = ((x % y) << 8) | (x / y);
            6: r = x * 2;
            7: r = x / 2;
            8: r = x & y;
            9: r = x | y;
            10: r = ~x & 255;
            11: r = ~(x & y) & 255;
            12: r = ~(x | y) & 255;
            13: r = x ^ y;
            14: r = ~(x ^ y) & 255;
            default: r = x;
        endcase
        return {e, r[15:0]};
    endfunction

    task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input int c, input int x, input int y, output int waited);
        waited = 0;
        command = 4'(c);
        a = 8'(x);
        b = 8'(y);
        in_valid = 1;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(posedge clk);
            #1;
            if (rnd) out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            waited++;
        end
        checks++;
        if (in_ready) sb.push_back(model(c, x, y));
        else begin
            errors++;
            $display("FAIL accept timeout: in_ready stayed %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected output: out=%h div_err=%b, required none", out, div_err);
            end else chk("result", {div_err, out}, sb.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int w, low;
        int tbl[8][3] = '{'{0, 255, 255}, '{3, 0, 0}, '{1, 255, 0}, '{6, 128, 0},
                          '{2, 0, 1}, '{14, 170, 85}, '{11, 255, 255}, '{7, 1, 0}};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset out", 17'(out), 0);
        chk("reset out_valid", 17'(out_valid), 0);
        chk("reset div_err", 17'(div_err), 0);
        chk("reset in_ready", 17'(in_ready), 0);
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("in_ready after reset", 17'(in_ready), 1);
        @(posedge clk);
        #1;
        issue(0, 200, 100, w);
        issue(2, 5, 9, w);
        chk("sub back-to-back wait", 17'(w), 0);
        drain();
        issue(4, 255, 255, w);
        low = 0;
        @(negedge clk);
        while (!in_ready && low < 50) begin
            low++;
            @(negedge clk);
        end
        chk("mul busy cycles", 17'(low), 8);
        drain();
        issue(5, 100, 7, w);
        issue(5, 37, 0, w);
        foreach (tbl[i]) issue(tbl[i][0], tbl[i][1], tbl[i][2], w);
        drain();
        out_ready = 0;
        issue(0, 1, 1, w);
        repeat (5) begin
            @(negedge clk);
            chk("held out_valid", 17'(out_valid), 1);
            chk("held out", 17'(out), 2);
            chk("held in_ready", 17'(in_ready), 0);
        end
        @(posedge clk);
        #1 out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        chk("out_valid after handshake", 17'(out_valid), 0);
        issue(4, 3, 4, w);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        sb.delete();
        @(negedge clk);
        chk("in_ready in reset", 17'(in_ready), 0);
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("out_valid after mid-op reset", 17'(out_valid), 0);
        chk("out after mid-op reset", 17'(out), 0);
        @(posedge clk);
        #1;
        issue(5, 9, 3, w);
        drain();
        out_ready = 0;
        issue(4, 13, 11, w);
        enable = 0;
        @(negedge clk);
        chk("in_ready while disabled", 17'(in_ready), 0);
        repeat (12) @(negedge clk);
        chk("out_valid while disabled", 17'(out_valid), 1);
        chk("out while disabled", 17'(out), 0);
        @(posedge clk);
        #1;
        enable = 1;
        out_ready = 1;
        drain();
        rnd = 1;
        for (int i = 0; i < 300; i++) begin
            out_ready = $urandom_range(0, 3) != 0;
            issue($urandom_range(0, 15), $urandom_range(0, 255),
                  $urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 255), w);
            repeat ($urandom_range(0, 2)) begin
                out_ready = $urandom_range(0, 3) != 0;
                @(posedge clk);
                #1;
            end
        end
        rnd = 0;
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
